// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_pkg;

    // Memory-stage sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } mem_state_e;

    // Bit positions inside store_valid
    localparam int SV_STORE_BIT  = 0;   // op is a store
    localparam int SV_WRADDR_BIT = 1;   // store also writes its address back (STU)

    // Watchdog limit for an outstanding memory operation
    localparam logic [7:0] MEM_TIMEOUT_MAX = 8'd255;

    // Execute-stage operation captured when a memory op is accepted
    typedef struct packed {
        logic [15:0] value;
        logic [2:0]  index;
        logic        write_vld;
        logic [15:0] addr;
        logic [1:0]  store_vld;
        logic [15:0] wdata;
    } mem_op_t;

endpackage

// File: rtl/mem_watchdog.sv
// Cycle counter bounding how long one memory operation may stay outstanding.
// Latency: expire is combinational from the count; count updates every clk.
// Backpressure: none; it only observes the sequencer's busy/start pulses.
module mem_watchdog
    import mem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic busy,
    output logic expire
);

    logic [7:0] cnt_q;

    // Count busy cycles, restarting for every new operation, saturating at the limit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 8'd0;
        end else if (start) begin
            cnt_q <= 8'd0;
        end else if (busy && (cnt_q != MEM_TIMEOUT_MAX)) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    // Fires in the busy cycle whose end brings the count to the limit,
    // so an operation occupies at most MEM_TIMEOUT_MAX cycles in REQ/WAIT.
    assign expire = busy && (cnt_q == (MEM_TIMEOUT_MAX - 8'd1));

endmodule

// File: rtl/mem_access.sv
// Memory stage: forwards ALU results and sequences one load/store at a time to dmem.
// Latency: ALU op 1 cycle; memory op 1 cycle after dmem accept (store) or rvalid (load).
// Backpressure: stall_mem_p1 holds execute while busy; dmem_ready gates the request.
// Optional build macro MEM_TIMEOUT_EN adds a 255-cycle watchdog and sticky mem_err_p1.
module mem_access
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ixmem_valid_p1,
    input  logic [15:0] dest_reg_value_ixmem_p1,
    input  logic [2:0]  dest_reg_index_ixmem_p1,
    input  logic        dest_reg_write_valid_ixmem_p1,
    input  logic [15:0] mem_addr_ixmem_p1,
    input  logic        ldst_valid_ixmem_p1,
    input  logic [1:0]  store_valid_ixmem_p1,
    input  logic [15:0] mem_data_in_ixmem_p1,
    output logic        stall_mem_p1,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [15:0] dmem_rdata,
    output logic [2:0]  dest_reg_index_memwb_p1,
    output logic [15:0] dest_reg_value_memwb_p1,
    output logic        dest_reg_write_valid_memwb_p1,
    output logic        mem_err_p1
);

    mem_state_e  state_q, state_d;
    mem_op_t     op_q;
    logic        start_op;
    logic        alu_pass;
    logic        complete;
    logic [15:0] wb_value_d;
    logic        wb_vld_d;
    logic        timeout_hit;
    logic        is_store;

    assign is_store = op_q.store_vld[SV_STORE_BIT];
    // Execute-stage inputs are only looked at while idle
    assign alu_pass = (state_q == ST_IDLE) && ixmem_valid_p1 && !ldst_valid_ixmem_p1;

    // Sequencer state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, completion detection and writeback value selection
    always_comb begin
        state_d    = state_q;
        start_op   = 1'b0;
        complete   = 1'b0;
        wb_value_d = op_q.value;
        wb_vld_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ixmem_valid_p1 && ldst_valid_ixmem_p1) begin
                    start_op = 1'b1;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                if (dmem_ready) begin
                    if (is_store) begin
                        complete   = 1'b1;
                        wb_value_d = op_q.value;
                        wb_vld_d   = op_q.store_vld[SV_WRADDR_BIT];
                        state_d    = ST_IDLE;
                    end else if (dmem_rvalid) begin
                        // Read data returned alongside the accept: skip WAIT
                        complete   = 1'b1;
                        wb_value_d = dmem_rdata;
                        wb_vld_d   = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (dmem_rvalid) begin
                    complete   = 1'b1;
                    wb_value_d = dmem_rdata;
                    wb_vld_d   = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A watchdog expiry abandons the op unless it finishes in that very cycle
        if (timeout_hit && !complete) begin
            state_d = ST_IDLE;
        end
    end

    // Hold the memory operation stable for the whole request/response exchange
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q <= '0;
        end else if (start_op) begin
            op_q.value     <= dest_reg_value_ixmem_p1;
            op_q.index     <= dest_reg_index_ixmem_p1;
            op_q.write_vld <= dest_reg_write_valid_ixmem_p1;
            op_q.addr      <= mem_addr_ixmem_p1;
            op_q.store_vld <= store_valid_ixmem_p1;
            op_q.wdata     <= mem_data_in_ixmem_p1;
        end
    end

    // Writeback register: one-cycle pulse per completed op, bubble otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dest_reg_index_memwb_p1       <= 3'd0;
            dest_reg_value_memwb_p1       <= 16'd0;
            dest_reg_write_valid_memwb_p1 <= 1'b0;
        end else if (alu_pass) begin
            dest_reg_index_memwb_p1       <= dest_reg_index_ixmem_p1;
            dest_reg_value_memwb_p1       <= dest_reg_value_ixmem_p1;
            dest_reg_write_valid_memwb_p1 <= dest_reg_write_valid_ixmem_p1;
        end else if (complete) begin
            dest_reg_index_memwb_p1       <= op_q.index;
            dest_reg_value_memwb_p1       <= wb_value_d;
            dest_reg_write_valid_memwb_p1 <= wb_vld_d;
        end else begin
            dest_reg_write_valid_memwb_p1 <= 1'b0;
        end
    end

    assign stall_mem_p1 = (state_q != ST_IDLE);
    assign dmem_req     = (state_q == ST_REQ);
    assign dmem_we      = dmem_req && is_store;
    assign dmem_addr    = dmem_req ? op_q.addr  : 16'd0;
    assign dmem_wdata   = dmem_req ? op_q.wdata : 16'd0;

`ifdef MEM_TIMEOUT_EN
    logic mem_err_q;

    mem_watchdog u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .start  (start_op),
        .busy   (stall_mem_p1),
        .expire (timeout_hit)
    );

    // Sticky error: once an op has been abandoned, only reset clears it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_err_q <= 1'b0;
        end else if (timeout_hit && !complete) begin
            mem_err_q <= 1'b1;
        end
    end

    assign mem_err_p1 = mem_err_q;
`else
    assign timeout_hit = 1'b0;
    assign mem_err_p1  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Randomized scoreboard bench for mem_access with a word-addressed memory model.
// Latency: checks 1-cycle ALU writeback and 1-cycle post-completion writeback.
// Backpressure: bench acts as dmem, with random ready/rvalid delays.
module tb_mem_access;

    logic        clk;
    logic        rst;
    logic        ixmem_valid_p1;
    logic [15:0] dest_reg_value_ixmem_p1;
    logic [2:0]  dest_reg_index_ixmem_p1;
    logic        dest_reg_write_valid_ixmem_p1;
    logic [15:0] mem_addr_ixmem_p1;
    logic        ldst_valid_ixmem_p1;
    logic [1:0]  store_valid_ixmem_p1;
    logic [15:0] mem_data_in_ixmem_p1;
    logic        stall_mem_p1;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        dmem_ready;
    logic        dmem_rvalid;
    logic [15:0] dmem_rdata;
    logic [2:0]  dest_reg_index_memwb_p1;
    logic [15:0] dest_reg_value_memwb_p1;
    logic        dest_reg_write_valid_memwb_p1;
    logic        mem_err_p1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [18:0] exp_q[$];                 // {index, value} of expected writebacks
    logic [15:0] mem_model [logic [15:0]];  // external memory contents

    mem_access dut (
        .clk                           (clk),
        .rst                           (rst),
        .ixmem_valid_p1                (ixmem_valid_p1),
        .dest_reg_value_ixmem_p1       (dest_reg_value_ixmem_p1),
        .dest_reg_index_ixmem_p1       (dest_reg_index_ixmem_p1),
        .dest_reg_write_valid_ixmem_p1 (dest_reg_write_valid_ixmem_p1),
        .mem_addr_ixmem_p1             (mem_addr_ixmem_p1),
        .ldst_valid_ixmem_p1           (ldst_valid_ixmem_p1),
        .store_valid_ixmem_p1          (store_valid_ixmem_p1),
        .mem_data_in_ixmem_p1          (mem_data_in_ixmem_p1),
        .stall_mem_p1                  (stall_mem_p1),
        .dmem_req                      (dmem_req),
        .dmem_we                       (dmem_we),
        .dmem_addr                     (dmem_addr),
        .dmem_wdata                    (dmem_wdata),
        .dmem_ready                    (dmem_ready),
        .dmem_rvalid                   (dmem_rvalid),
        .dmem_rdata                    (dmem_rdata),
        .dest_reg_index_memwb_p1       (dest_reg_index_memwb_p1),
        .dest_reg_value_memwb_p1       (dest_reg_value_memwb_p1),
        .dest_reg_write_valid_memwb_p1 (dest_reg_write_valid_memwb_p1),
        .mem_err_p1                    (mem_err_p1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 16'h5A5A;
    endfunction

    // Random values on the execute-stage bus while no op is offered
    task automatic drive_idle_junk();
        ixmem_valid_p1                = 1'b0;
        dest_reg_value_ixmem_p1       = 16'($urandom);
        dest_reg_index_ixmem_p1       = 3'($urandom);
        dest_reg_write_valid_ixmem_p1 = 1'($urandom);
        mem_addr_ixmem_p1             = 16'($urandom);
        ldst_valid_ixmem_p1           = 1'($urandom);
        store_valid_ixmem_p1          = 2'($urandom);
        mem_data_in_ixmem_p1          = 16'($urandom);
    endtask

    // Monitor: every writeback pulse must match the oldest expected one
    always @(negedge clk) begin
        if (rst && dest_reg_write_valid_memwb_p1) begin
            if (exp_q.size() == 0) begin
                check("wb_unexpected", {13'd0, dest_reg_index_memwb_p1, dest_reg_value_memwb_p1}, 32'hFFFF_FFFF);
            end else begin
                logic [18:0] e;
                e = exp_q.pop_front();
                check("wb_data", {13'd0, dest_reg_index_memwb_p1, dest_reg_value_memwb_p1}, {13'd0, e});
            end
        end
    end

    // Offer one op and play the memory side; called and returns on a falling edge
    task automatic issue(input logic ldst, input logic [1:0] sv, input logic [15:0] val,
                         input logic [2:0] idx, input logic wv, input logic [15:0] addr,
                         input logic [15:0] wdata, input int rdy_dly, input int rv_dly);
        int   guard;
        logic is_load;
        logic exp_wv;
        guard = 0;
        while (stall_mem_p1 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) check("issue_wait_idle", 32'(stall_mem_p1), 32'd0);
        is_load = ldst && !sv[0];
        exp_wv  = !ldst ? wv : (is_load ? 1'b1 : sv[1]);
        if (exp_wv) exp_q.push_back({idx, (is_load ? mem_rd(addr) : val)});
        ixmem_valid_p1                = 1'b1;
        dest_reg_value_ixmem_p1       = val;
        dest_reg_index_ixmem_p1       = idx;
        dest_reg_write_valid_ixmem_p1 = wv;
        mem_addr_ixmem_p1             = addr;
        ldst_valid_ixmem_p1           = ldst;
        store_valid_ixmem_p1          = sv;
        mem_data_in_ixmem_p1          = wdata;
        dmem_ready  = 1'b0;
        dmem_rvalid = 1'($urandom);   // idle: must be ignored
        dmem_rdata  = 16'($urandom);
        @(negedge clk);
        drive_idle_junk();
        if (!ldst) begin
            dmem_rvalid = 1'($urandom);
            check("alu_stall", 32'(stall_mem_p1), 32'd0);
            check("alu_wv_lat1", 32'(dest_reg_write_valid_memwb_p1), 32'(exp_wv));
            return;
        end
        dmem_rvalid = is_load ? 1'b0 : 1'($urandom);
        for (int k = 0; k <= rdy_dly; k++) begin
            check("req_stall", 32'(stall_mem_p1), 32'd1);
            check("req_vld", 32'(dmem_req), 32'd1);
            check("req_addr", 32'(dmem_addr), 32'(addr));
            check("req_we", 32'(dmem_we), 32'(sv[0]));
            if (!is_load) check("req_wdata", 32'(dmem_wdata), 32'(wdata));
            if (k == rdy_dly) begin
                dmem_ready = 1'b1;
                if (is_load && rv_dly == 0) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = mem_rd(addr);
                end
                if (!is_load) mem_model[addr] = wdata;
            end
            @(negedge clk);
            dmem_ready  = 1'b0;
            dmem_rvalid = is_load ? 1'b0 : 1'($urandom);
            dmem_rdata  = 16'($urandom);
        end
        if (is_load && rv_dly > 0) begin
            for (int k = 1; k <= rv_dly; k++) begin
                check("wait_stall", 32'(stall_mem_p1), 32'd1);
                check("wait_req_low", 32'(dmem_req), 32'd0);
                if (k == rv_dly) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = mem_rd(addr);
                end
                @(negedge clk);
                dmem_rvalid = 1'b0;
                dmem_rdata  = 16'($urandom);
            end
        end
        check("done_idle", 32'(stall_mem_p1), 32'd0);
        check("done_wv", 32'(dest_reg_write_valid_memwb_p1), 32'(exp_wv));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, 32'(stall_mem_p1), 32'd0);
        check({tag, "_req"}, 32'(dmem_req), 32'd0);
        check({tag, "_we"}, 32'(dmem_we), 32'd0);
        check({tag, "_addr"}, 32'(dmem_addr), 32'd0);
        check({tag, "_wdata"}, 32'(dmem_wdata), 32'd0);
        check({tag, "_wb_idx"}, 32'(dest_reg_index_memwb_p1), 32'd0);
        check({tag, "_wb_val"}, 32'(dest_reg_value_memwb_p1), 32'd0);
        check({tag, "_wb_vld"}, 32'(dest_reg_write_valid_memwb_p1), 32'd0);
        check({tag, "_err"}, 32'(mem_err_p1), 32'd0);
    endtask

    // Global time bound so the run can never hang
    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int cnt;
        rst = 1'b0;
        drive_idle_junk();
        dmem_ready  = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 16'd0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // ALU op: value 0x1234 to r5
        issue(1'b0, 2'b00, 16'h1234, 3'd5, 1'b1, 16'h0000, 16'h0000, 0, 0);
        // Load 0x0040: ready after 2 cycles, rvalid 3 later
        mem_model[16'h0040] = 16'hBEEF;
        issue(1'b1, 2'b00, 16'h0000, 3'd2, 1'b1, 16'h0040, 16'h0000, 2, 3);
        // Store 0x00AA to 0x0010, accepted at once, no writeback
        issue(1'b1, 2'b01, 16'h7777, 3'd3, 1'b1, 16'h0010, 16'h00AA, 0, 0);
        // STU to 0x0022: writes the address back
        issue(1'b1, 2'b11, 16'h0022, 3'd4, 1'b1, 16'h0022, 16'h5555, 1, 0);
        // Load with ready and rvalid together: reads back the earlier store
        issue(1'b1, 2'b00, 16'h0000, 3'd6, 1'b1, 16'h0010, 16'h0000, 0, 0);

        // Random traffic over a small address window
        for (int n = 0; n < 200; n++) begin
            int kind;
            kind = $urandom_range(0, 3);
            case (kind)
                0: issue(1'b0, 2'($urandom), 16'($urandom), 3'($urandom), 1'($urandom),
                         16'($urandom), 16'($urandom), 0, 0);
                1: issue(1'b1, 2'b00, 16'($urandom), 3'($urandom), 1'($urandom),
                         16'($urandom_range(0, 15)), 16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
                2: issue(1'b1, 2'b01, 16'($urandom), 3'($urandom), 1'($urandom),
                         16'($urandom_range(0, 15)), 16'($urandom), $urandom_range(0, 3), 0);
                default: issue(1'b1, 2'b11, 16'($urandom), 3'($urandom), 1'($urandom),
                         16'($urandom_range(0, 15)), 16'($urandom), $urandom_range(0, 3), 0);
            endcase
        end

        // Reset while a load waits for data: abandoned, no writeback
        ixmem_valid_p1                = 1'b1;
        dest_reg_value_ixmem_p1       = 16'h0000;
        dest_reg_index_ixmem_p1       = 3'd1;
        dest_reg_write_valid_ixmem_p1 = 1'b1;
        mem_addr_ixmem_p1             = 16'h0033;
        ldst_valid_ixmem_p1           = 1'b1;
        store_valid_ixmem_p1          = 2'b00;
        mem_data_in_ixmem_p1          = 16'h0000;
        dmem_rvalid                   = 1'b0;
        @(negedge clk);
        drive_idle_junk();
        dmem_ready = 1'b1;
        @(negedge clk);
        dmem_ready = 1'b0;
        check("rst_pre_wait_stall", 32'(stall_mem_p1), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("mid_rst");
        @(negedge clk);
        rst = 1'b1;
        dmem_rvalid = 1'b1;        // late data for the abandoned load
        dmem_rdata  = 16'hDEAD;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        check("post_rst_idle", 32'(stall_mem_p1), 32'd0);
        @(negedge clk);

`ifdef MEM_TIMEOUT_EN
        // Load accepted but data never returns: abandoned after 255 busy cycles
        issue(1'b0, 2'b00, 16'h0001, 3'd0, 1'b0, 16'h0, 16'h0, 0, 0);
        ixmem_valid_p1                = 1'b1;
        dest_reg_index_ixmem_p1       = 3'd7;
        dest_reg_write_valid_ixmem_p1 = 1'b1;
        mem_addr_ixmem_p1             = 16'h0050;
        ldst_valid_ixmem_p1           = 1'b1;
        store_valid_ixmem_p1          = 2'b00;
        @(negedge clk);
        drive_idle_junk();
        cnt = 0;
        while (stall_mem_p1 && cnt < 400) begin
            cnt++;
            dmem_ready = (cnt == 1);
            @(negedge clk);
        end
        dmem_ready = 1'b0;
        check("timeout_cycles", 32'(cnt), 32'd255);
        check("timeout_err", 32'(mem_err_p1), 32'd1);
        repeat (3) @(negedge clk);
        check("timeout_err_sticky", 32'(mem_err_p1), 32'd1);
        rst = 1'b0;
        #1;
        check("timeout_err_rst", 32'(mem_err_p1), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
`else
        cnt = 0;
        check("err_tied_low", 32'(mem_err_p1), 32'(cnt));
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
